arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-input, valid/ready multiplexer with a registered output, replacing the combinational 4:1 datapath selectors where the selected source must be held or several producers share one consumer. Two modes: explicit select, where a control field picks the channel, and round-robin arbitration among valid channels. One-cycle latency, full throughput, and a sticky error flag for out-of-range selects. Sits between multiple 64-bit producers (e.g. ALU, load unit, CSR path) and a single writeback/consumer port.

## Interface
- `WIDTH`, 64: data width per channel.
- `NUM_IN`, 4: number of input channels, 2..16.
- `SEL_W`, `$clog2(NUM_IN)`: width of select/channel fields (derived, not overridden).

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 1: 0 = select (MODE_SEL), 1 = round-robin (MODE_RR).
- `sel` in SEL_W: channel index used in MODE_SEL.
- `in_valid` in NUM_IN: per-channel valid.
- `in_data` in NUM_IN*WIDTH: flattened; channel i at `[i*WIDTH +: WIDTH]`.
- `in_ready` out NUM_IN: per-channel ready, at most one bit set.
- `out_valid` out 1: output register holds a word.
- `out_data` out WIDTH: held word.
- `out_chan` out SEL_W: index of the channel that supplied `out_data`.
- `out_ready` in 1: consumer accepts.
- `sel_err` out 1: sticky, set on out-of-range select.

## Operation
- `free = !out_valid || out_ready`. New grant decisions are made only when free.
- MODE_SEL: grant channel `sel` iff `sel < NUM_IN` and `in_valid[sel]`. Otherwise no grant.
- MODE_RR: grant the first channel with `in_valid` set, searching upward from `rr_ptr` with wrap to 0. No valid channel means no grant.
- `in_ready[g] = free && grant valid && !reset`. All other bits are 0. `in_ready` is combinational from `out_ready`, `mode`, `sel`, `in_valid` and `rr_ptr`.
- Transfer on channel g: `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- Free with no grant: `out_valid <= 0`; `out_data` and `out_chan` hold their values.
- Not free: the output register holds, regardless of `in_valid`, `sel` or `mode` changes.
- `rr_ptr` updates to `(g+1) mod NUM_IN` only on a MODE_RR transfer. It holds in MODE_SEL.
- `sel_err` is set when `mode==0 && free && sel >= NUM_IN`. It clears only on reset. This condition is only reachable for non-power-of-2 NUM_IN.
- Producers must not make `in_valid` depend on `in_ready`. A producer must hold `in_valid`/`in_data` until transfer. Dropping `in_valid` before transfer is legal; the channel is simply not granted.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `sel_err=0`, `rr_ptr=0`. `in_ready` is all-zero while `reset` is high.
- Latency: an input word accepted at edge k is visible on `out_*` after edge k.
- Throughput: 1 word/cycle when `out_ready` is held high. The same cycle can see a consumer accept and a producer transfer.
- Mode switch: takes effect at the next grant decision. A held word is never dropped or duplicated.
- Reset mid-operation: the held word is discarded and the pointer returns to 0.
- RR wrap: with `rr_ptr = NUM_IN-1`, search order is NUM_IN-1, 0, 1, …

## Structure
- Package `arb_mux_pkg`:
  - typedef enum logic `arb_mode_t {MODE_SEL=0, MODE_RR=1}`;
  - constant `ARB_DEFAULT_WIDTH = 64`.
- Sub-module `rr_pick`: combinational rotating priority encoder with parameter NUM_IN.
  - Inputs: req[NUM_IN], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
- Top module: free/grant logic, output register, `rr_ptr`, `sel_err`.

## Test plan
- Reset with all `in_valid=4'b1111` -> `out_valid=0`, `in_ready=0`, `sel_err=0`. First edge after reset release in MODE_RR grants ch0.
- MODE_SEL, `sel=2`, `in_data[2]=64'hDEAD_BEEF`, `out_ready=1` -> `in_ready=4'b0100`. Next cycle `out_data=64'hDEAD_BEEF`, `out_chan=2`.
- MODE_RR, all four valid, `out_ready=1` for 8 cycles -> `out_chan` sequence 0,1,2,3,0,1,2,3.
- Backpressure: `out_ready=0` for 3 cycles with a word held -> `out_data` stable, `in_ready=0`. `out_ready=1` then moves the next word in the same cycle.
- NUM_IN=3, MODE_SEL, `sel=3` -> no grant, `out_valid` falls to 0. `sel_err=1` and stays 1 after `sel` returns to 0, until reset.
- Mode flip RR->SEL while `out_valid=1` and `out_ready=0` -> held word unchanged. The next grant follows `sel` and `rr_ptr` is unchanged.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// arb_mux shared types and constants.
// Imported by the arbiter top and its round-robin picker.
package arb_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } arb_mode_t;

    localparam int ARB_DEFAULT_WIDTH = 64;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr,
// wrapping back to channel 0.
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    int               w_pos;
    logic [SEL_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_pos     = 0;
        w_idx     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NUM_IN) begin
                w_pos = w_pos - NUM_IN;
            end
            w_idx = SEL_W'(w_pos);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-input valid/ready multiplexer with registered output,
// explicit-select or round-robin arbitration, sticky select error.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH  = ARB_DEFAULT_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam logic [SEL_W:0]   NUM_L  = (SEL_W + 1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_L = SEL_W'(NUM_IN - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_rr_ptr;
    logic             r_sel_err;

    arb_mode_t        w_mode;
    logic             w_free;
    logic             w_sel_ok;
    logic             w_rr_v;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_v;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_xfer;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_rr_v),
        .gnt_idx   (w_rr_idx)
    );

    // Grant decision for the current cycle in either mode.
    always_comb begin
        w_mode    = arb_mode_t'(mode);
        w_free    = !r_out_valid || out_ready;
        w_sel_ok  = ({1'b0, sel} < NUM_L);
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        if (w_mode == MODE_RR) begin
            w_gnt_v   = w_rr_v;
            w_gnt_idx = w_rr_idx;
        end else if (w_sel_ok) begin
            w_gnt_v   = in_valid[sel];
            w_gnt_idx = sel;
        end
        w_xfer = w_free && w_gnt_v && !reset;
    end

    // One-hot ready toward the granted producer only.
    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Output register, round-robin pointer and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
            r_sel_err   <= 1'b0;
        end else if (w_free) begin
            if (w_mode == MODE_SEL && !w_sel_ok) begin
                r_sel_err <= 1'b1;
            end
            r_out_valid <= w_gnt_v;
            if (w_gnt_v) begin
                r_out_data <= in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
                r_out_chan <= w_gnt_idx;
                if (w_mode == MODE_RR) begin
                    r_rr_ptr <= (w_gnt_idx == LAST_L) ? '0
                                                      : w_gnt_idx + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: 4-input and 3-input instances,
// reference model plus hand-computed directed expectations.
module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-input instance
    logic         rst4 = 1'b1;
    logic         mode4 = 1'b1;
    logic [1:0]   sel4 = '0;
    logic [3:0]   v4 = 4'b1111;
    logic [255:0] d4 = '0;
    logic [3:0]   rdy4;
    logic         ov4;
    logic [63:0]  od4;
    logic [1:0]   oc4;
    logic         ordy4 = 1'b1;
    logic         err4;

    // 3-input instance
    logic         rst3 = 1'b1;
    logic         mode3 = 1'b0;
    logic [1:0]   sel3 = '0;
    logic [2:0]   v3 = 3'b111;
    logic [191:0] d3 = '0;
    logic [2:0]   rdy3;
    logic         ov3;
    logic [63:0]  od3;
    logic [1:0]   oc3;
    logic         ordy3 = 1'b1;
    logic         err3;

    arb_mux #(.WIDTH(64), .NUM_IN(4)) dut4 (
        .clk(clk), .reset(rst4), .mode(mode4), .sel(sel4),
        .in_valid(v4), .in_data(d4), .in_ready(rdy4),
        .out_valid(ov4), .out_data(od4), .out_chan(oc4),
        .out_ready(ordy4), .sel_err(err4)
    );

    arb_mux #(.WIDTH(64), .NUM_IN(3)) dut3 (
        .clk(clk), .reset(rst3), .mode(mode3), .sel(sel3),
        .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_chan(oc3),
        .out_ready(ordy3), .sel_err(err3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference model: index 0 = 4-input, 1 = 3-input.
    bit          m_ov [2];
    logic [63:0] m_od [2];
    int          m_oc [2];
    int          m_ptr[2];
    bit          m_err[2];

    function automatic int grant(int n, bit md, int s,
                                 logic [3:0] v, int ptr);
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic step(int d, int n, bit rst, bit md, int s,
                        logic [3:0] v, logic [255:0] data, bit ordy);
        int g;
        if (rst) begin
            m_ov[d] = 0; m_od[d] = '0; m_oc[d] = 0;
            m_ptr[d] = 0; m_err[d] = 0;
            return;
        end
        if (m_ov[d] && !ordy) return;
        if (!md && s >= n) m_err[d] = 1;
        g = grant(n, md, s, v, m_ptr[d]);
        if (g < 0) begin
            m_ov[d] = 0;
        end else begin
            m_ov[d] = 1;
            m_od[d] = data[g*64 +: 64];
            m_oc[d] = g;
            if (md) m_ptr[d] = (g + 1) % n;
        end
    endtask

    function automatic logic [3:0] exp_rdy(int d, int n, bit rst, bit md,
                                           int s, logic [3:0] v, bit ordy);
        int g;
        logic [3:0] r;
        r = '0;
        g = grant(n, md, s, v, m_ptr[d]);
        if (!rst && (!m_ov[d] || ordy) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        step(0, 4, rst4, mode4, int'(sel4), v4, d4, ordy4);
        step(1, 3, rst3, mode3, int'(sel3), {1'b0, v3},
             {64'h0, d3}, ordy3);
    end

    always @(negedge clk) begin
        chk("m4_valid", 64'(ov4), 64'(m_ov[0]));
        chk("m4_err", 64'(err4), 64'(m_err[0]));
        chk("m4_ready", 64'(rdy4),
            64'(exp_rdy(0, 4, rst4, mode4, int'(sel4), v4, ordy4)));
        if (m_ov[0]) begin
            chk("m4_data", od4, m_od[0]);
            chk("m4_chan", 64'(oc4), 64'(m_oc[0]));
        end
        chk("m3_valid", 64'(ov3), 64'(m_ov[1]));
        chk("m3_err", 64'(err3), 64'(m_err[1]));
        chk("m3_ready", 64'(rdy3),
            64'(exp_rdy(1, 3, rst3, mode3, int'(sel3), {1'b0, v3}, ordy3)));
        if (m_ov[1]) begin
            chk("m3_data", od3, m_od[1]);
            chk("m3_chan", 64'(oc3), 64'(m_oc[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int rr_seq[8];
    int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        for (int i = 0; i < 4; i++) d4[i*64 +: 64] = 64'h1000 + 64'(i);
        for (int i = 0; i < 3; i++) d3[i*64 +: 64] = 64'h3000 + 64'(i);

        // Reset with all channels valid
        cyc(); cyc();
        chk("rst_valid", 64'(ov4), 64'd0);
        chk("rst_ready", 64'(rdy4), 64'd0);
        chk("rst_err", 64'(err4), 64'd0);
        rst4 = 1'b0;

        // Round-robin over four valid channels
        for (int i = 0; i < 8; i++) begin
            cyc();
            rr_seq[i] = int'(oc4);
            chk("rr_valid", 64'(ov4), 64'd1);
        end
        for (int i = 0; i < 8; i++) chk("rr_seq", 64'(rr_seq[i]),
                                        64'(rr_exp[i]));

        // Explicit select of channel 2
        mode4 = 1'b0; sel4 = 2'd2;
        d4[2*64 +: 64] = 64'hDEAD_BEEF;
        #1;
        chk("sel_ready", 64'(rdy4), 64'b0100);
        cyc();
        chk("sel_data", od4, 64'hDEAD_BEEF);
        chk("sel_chan", 64'(oc4), 64'd2);

        // Backpressure holds the word
        ordy4 = 1'b0; sel4 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_data", od4, 64'hDEAD_BEEF);
            chk("bp_ready", 64'(rdy4), 64'd0);
        end
        ordy4 = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(rdy4), 64'b0010);
        cyc();
        chk("bp_rel_chan", 64'(oc4), 64'd1);
        chk("bp_rel_data", od4, 64'h1001);

        // RR grant from pointer 0, then flip to SEL while held
        mode4 = 1'b1;
        cyc();
        chk("flip_rr_chan", 64'(oc4), 64'd0);
        ordy4 = 1'b0;
        cyc();
        mode4 = 1'b0; sel4 = 2'd3;
        cyc();
        chk("flip_hold_chan", 64'(oc4), 64'd0);
        chk("flip_hold_data", od4, 64'h1000);
        ordy4 = 1'b1;
        cyc();
        chk("flip_sel_chan", 64'(oc4), 64'd3);
        mode4 = 1'b1;
        cyc();
        chk("flip_ptr_kept", 64'(oc4), 64'd1);

        // Sparse valids with wrap: ptr=2, only ch0 and ch1 valid
        v4 = 4'b0011;
        cyc();
        chk("wrap_chan", 64'(oc4), 64'd0);
        v4 = 4'b0000;
        cyc();
        chk("idle_valid", 64'(ov4), 64'd0);
        chk("idle_data_hold", od4, 64'h1000);
        v4 = 4'b1111;
        rst4 = 1'b1;
        cyc();
        chk("mid_rst_valid", 64'(ov4), 64'd0);
        rst4 = 1'b0;
        cyc();
        chk("mid_rst_chan", 64'(oc4), 64'd0);

        // 3-input instance: out-of-range select
        rst3 = 1'b0;
        cyc();
        chk("n3_chan0", 64'(oc3), 64'd0);
        sel3 = 2'd3;
        cyc();
        chk("n3_bad_valid", 64'(ov3), 64'd0);
        chk("n3_err_set", 64'(err3), 64'd1);
        sel3 = 2'd0;
        cyc();
        chk("n3_err_sticky", 64'(err3), 64'd1);
        chk("n3_back_valid", 64'(ov3), 64'd1);
        rst3 = 1'b1;
        cyc();
        chk("n3_err_clr", 64'(err3), 64'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
